// File: rtl/pe_psum_emitter_pkg.sv
// ============================================================================
// Module  : pe_psum_emitter_pkg
// Brief   : Shared widths and FSM state type for the PE psum emitter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pe_psum_emitter_pkg;

    // Default widths, matching the controller-wide parameter set
    localparam int PKG_W_SIZE     = 8;
    localparam int PKG_W_CHANNEL  = 6;
    localparam int PKG_TOUT       = 4;
    localparam int PKG_PSUM_DW    = 32;
    localparam int PKG_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } emit_state_e;

endpackage : pe_psum_emitter_pkg

`default_nettype wire

// File: rtl/pe_psum_emitter_psum_fifo.sv
// ============================================================================
// Module  : pe_psum_emitter_psum_fifo
// Brief   : Synchronous show-ahead FIFO holding completed psum vectors.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pe_psum_emitter_psum_fifo
    import pe_psum_emitter_pkg::*;
#(
    parameter int DW    = PKG_TOUT * PKG_PSUM_DW,
    parameter int DEPTH = PKG_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule : pe_psum_emitter_psum_fifo

`default_nettype wire

// File: rtl/pe_psum_emitter.sv
// ============================================================================
// Module  : pe_psum_emitter
// Brief   : Buffers PE-array psum vectors and emits coordinate-tagged beats.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pe_psum_emitter
    import pe_psum_emitter_pkg::*;
#(
    parameter int W_SIZE          = PKG_W_SIZE,
    parameter int W_CHANNEL       = PKG_W_CHANNEL,
    parameter int Tout            = PKG_TOUT,
    parameter int PSUM_DW         = PKG_PSUM_DW,
    parameter int PE_ACCO_FLAT_BW = Tout * PSUM_DW,
    parameter int FIFO_DEPTH      = PKG_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [W_SIZE-1:0]          q_width,
    input  logic [W_SIZE-1:0]          q_height,
    input  logic [W_CHANNEL-1:0]       q_channel,
    input  logic [W_CHANNEL-1:0]       q_channel_out,
    input  logic                       acc_vld_i,
    input  logic [PE_ACCO_FLAT_BW-1:0] acc_data_i,
    output logic                       acc_rdy_o,
    input  logic                       pp_stall_i,
    output logic                       pe_vld_o,
    output logic [PE_ACCO_FLAT_BW-1:0] pe_data_o,
    output logic [W_SIZE-1:0]          pe_row_o,
    output logic [W_SIZE-1:0]          pe_col_o,
    output logic [W_CHANNEL-1:0]       pe_chn_o,
    output logic [W_CHANNEL-1:0]       pe_chn_out_o,
    output logic                       pe_is_last_chn,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int TOTAL_W = 2*W_SIZE + 2*W_CHANNEL;

    emit_state_e state_q, state_d;

    logic [W_SIZE-1:0]          width_q, height_q;
    logic [W_CHANNEL-1:0]       chn_num_q, cout_num_q;
    logic [TOTAL_W-1:0]         total_q, acc_cnt_q;
    logic [W_SIZE-1:0]          col_q, row_q;
    logic [W_CHANNEL-1:0]       chn_q, cout_q;

    logic                       pe_vld_q;
    logic [PE_ACCO_FLAT_BW-1:0] pe_data_q;
    logic [W_SIZE-1:0]          pe_row_q, pe_col_q;
    logic [W_CHANNEL-1:0]       pe_chn_q, pe_cout_q;
    logic                       pe_last_q;
    logic                       done_q;

    logic                       start_acc;
    logic                       dims_zero;
    logic                       push, pop;
    logic                       fifo_full, fifo_empty;
    logic [PE_ACCO_FLAT_BW-1:0] fifo_rdata;
    logic                       col_last, row_last, chn_last, cout_last;
    logic                       final_beat;
    logic [TOTAL_W-1:0]         total_in;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign dims_zero = (q_width == '0) || (q_height == '0) ||
                       (q_channel == '0) || (q_channel_out == '0);
    assign total_in  = TOTAL_W'(q_width) * TOTAL_W'(q_height) *
                       TOTAL_W'(q_channel) * TOTAL_W'(q_channel_out);

    assign acc_rdy_o = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < total_q);
    assign push      = acc_vld_i && acc_rdy_o;
    assign pop       = (state_q == ST_RUN) && !fifo_empty && !pp_stall_i;

    assign col_last   = (col_q  == width_q    - W_SIZE'(1));
    assign row_last   = (row_q  == height_q   - W_SIZE'(1));
    assign chn_last   = (chn_q  == chn_num_q  - W_CHANNEL'(1));
    assign cout_last  = (cout_q == cout_num_q - W_CHANNEL'(1));
    assign final_beat = col_last && row_last && chn_last && cout_last;

    pe_psum_emitter_psum_fifo #(
        .DW    (PE_ACCO_FLAT_BW),
        .DEPTH (FIFO_DEPTH)
    ) u_psum_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i (acc_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = dims_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop && final_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            chn_num_q  <= '0;
            cout_num_q <= '0;
            total_q    <= '0;
            acc_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // done trails entry into DONE by one cycle, after the final beat
            done_q  <= (state_q == ST_DONE);
            if (start_acc) begin
                width_q    <= q_width;
                height_q   <= q_height;
                chn_num_q  <= q_channel;
                cout_num_q <= q_channel_out;
                total_q    <= total_in;
                acc_cnt_q  <= '0;
            end else if (push) begin
                acc_cnt_q <= acc_cnt_q + TOTAL_W'(1);
            end
        end
    end

    // Coordinate walk: col fastest, then row, then input chn, then output chn
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q  <= '0;
            row_q  <= '0;
            chn_q  <= '0;
            cout_q <= '0;
        end else if (start_acc) begin
            col_q  <= '0;
            row_q  <= '0;
            chn_q  <= '0;
            cout_q <= '0;
        end else if (pop) begin
            if (!col_last) begin
                col_q <= col_q + W_SIZE'(1);
            end else begin
                col_q <= '0;
                if (!row_last) begin
                    row_q <= row_q + W_SIZE'(1);
                end else begin
                    row_q <= '0;
                    if (!chn_last) begin
                        chn_q <= chn_q + W_CHANNEL'(1);
                    end else begin
                        chn_q  <= '0;
                        cout_q <= cout_q + W_CHANNEL'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_vld_q  <= 1'b0;
            pe_data_q <= '0;
            pe_row_q  <= '0;
            pe_col_q  <= '0;
            pe_chn_q  <= '0;
            pe_cout_q <= '0;
            pe_last_q <= 1'b0;
        end else begin
            pe_vld_q <= pop;
            if (pop) begin
                pe_data_q <= fifo_rdata;
                pe_row_q  <= row_q;
                pe_col_q  <= col_q;
                pe_chn_q  <= chn_q;
                pe_cout_q <= cout_q;
                pe_last_q <= chn_last;
            end
        end
    end

    assign pe_vld_o       = pe_vld_q;
    assign pe_data_o      = pe_data_q;
    assign pe_row_o       = pe_row_q;
    assign pe_col_o       = pe_col_q;
    assign pe_chn_o       = pe_chn_q;
    assign pe_chn_out_o   = pe_cout_q;
    assign pe_is_last_chn = pe_last_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;

endmodule : pe_psum_emitter

`default_nettype wire

// File: tb/tb_pe_psum_emitter.sv
// ============================================================================
// Module  : tb_pe_psum_emitter
// Brief   : Randomized self-checking bench for pe_psum_emitter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_psum_emitter;

    localparam int W_SIZE    = 8;
    localparam int W_CHANNEL = 6;
    localparam int TOUT      = 4;
    localparam int PSUM_DW   = 32;
    localparam int BW        = TOUT * PSUM_DW;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start_i;
    logic [W_SIZE-1:0]    q_width, q_height;
    logic [W_CHANNEL-1:0] q_channel, q_channel_out;
    logic                 acc_vld_i;
    logic [BW-1:0]        acc_data_i;
    logic                 acc_rdy_o;
    logic                 pp_stall_i;
    logic                 pe_vld_o;
    logic [BW-1:0]        pe_data_o;
    logic [W_SIZE-1:0]    pe_row_o, pe_col_o;
    logic [W_CHANNEL-1:0] pe_chn_o, pe_chn_out_o;
    logic                 pe_is_last_chn;
    logic                 busy_o;
    logic                 done_o;

    always #5 clk = ~clk;

    pe_psum_emitter #(
        .W_SIZE          (W_SIZE),
        .W_CHANNEL       (W_CHANNEL),
        .Tout            (TOUT),
        .PSUM_DW         (PSUM_DW),
        .PE_ACCO_FLAT_BW (BW),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .q_width        (q_width),
        .q_height       (q_height),
        .q_channel      (q_channel),
        .q_channel_out  (q_channel_out),
        .acc_vld_i      (acc_vld_i),
        .acc_data_i     (acc_data_i),
        .acc_rdy_o      (acc_rdy_o),
        .pp_stall_i     (pp_stall_i),
        .pe_vld_o       (pe_vld_o),
        .pe_data_o      (pe_data_o),
        .pe_row_o       (pe_row_o),
        .pe_col_o       (pe_col_o),
        .pe_chn_o       (pe_chn_o),
        .pe_chn_out_o   (pe_chn_out_o),
        .pe_is_last_chn (pe_is_last_chn),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state for the pass in flight
    logic [BW-1:0] exp_q [$];
    bit in_pass = 0;
    int m_w, m_h, m_c, m_co, m_total, m_acc, beat;
    int start_cyc, first_cyc, last_cyc, done_seen;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"},   pe_vld_o, 0);
        check({tag, "_data"},  pe_data_o, 0);
        check({tag, "_row"},   pe_row_o, 0);
        check({tag, "_col"},   pe_col_o, 0);
        check({tag, "_chn"},   pe_chn_o, 0);
        check({tag, "_cout"},  pe_chn_out_o, 0);
        check({tag, "_last"},  pe_is_last_chn, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_rdy"},   acc_rdy_o, 0);
    endtask

    task automatic monitor(input bit stall_at_edge);
        bit avail;
        logic [BW-1:0] d;
        int col, row, chn, cout;
        if (in_pass && m_acc >= m_total) check("rdy_after_total", acc_rdy_o, 0);
        if (stall_at_edge) check("no_beat_on_stall", pe_vld_o, 0);
        if (pe_vld_o) begin
            avail = in_pass && (exp_q.size() > 0) && (beat < m_total);
            check("beat_allowed", pe_vld_o, avail);
            if (avail) begin
                d    = exp_q.pop_front();
                col  = beat % m_w;
                row  = (beat / m_w) % m_h;
                chn  = (beat / (m_w * m_h)) % m_c;
                cout = beat / (m_w * m_h * m_c);
                check("beat_data", pe_data_o, d);
                check("beat_col",  pe_col_o, col);
                check("beat_row",  pe_row_o, row);
                check("beat_chn",  pe_chn_o, chn);
                check("beat_cout", pe_chn_out_o, cout);
                check("beat_last_chn", pe_is_last_chn, (chn == m_c - 1));
                if (beat == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat++;
            end
        end
        if (done_o && in_pass) begin
            done_seen++;
            check("done_all_beats", beat, m_total);
            check("done_busy_low", busy_o, 0);
            if (m_total == 0) check("done_zero_delay", cyc - start_cyc, 2);
            else              check("done_after_last", cyc - last_cyc, 1);
        end
    endtask

    // Inputs are already set for the coming edge; record the handshake, clock, then observe
    task automatic step();
        bit hs, st;
        hs = acc_vld_i && acc_rdy_o;
        st = pp_stall_i;
        if (hs && in_pass) begin
            exp_q.push_back(acc_data_i);
            m_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor(st);
    endtask

    // mode 0: acc_vld held, no stall; 1: random vld/stall; 2: stall first 10 cycles
    task automatic run_pass(input int w, input int h, input int c, input int co,
                            input int mode, input int abort_after);
        logic [31:0] tag32;
        q_width       = W_SIZE'(w);
        q_height      = W_SIZE'(h);
        q_channel     = W_CHANNEL'(c);
        q_channel_out = W_CHANNEL'(co);
        start_i = 1'b1; acc_vld_i = 1'b0; pp_stall_i = 1'b0;
        m_w = w; m_h = h; m_c = c; m_co = co;
        m_total = w * h * c * co;
        m_acc = 0; beat = 0; done_seen = 0; first_cyc = -100; last_cyc = -100;
        exp_q.delete();
        in_pass   = 1;
        start_cyc = cyc;
        step();
        check("busy_after_start", busy_o, 1);
        for (int it = 0; it < 400 && done_seen == 0; it++) begin
            start_i = (it == 1 && m_total >= 2);
            if (it == 0 || start_i) begin
                q_width       = W_SIZE'($urandom_range(0, 7));
                q_height      = W_SIZE'($urandom_range(0, 7));
                q_channel     = W_CHANNEL'($urandom_range(0, 7));
                q_channel_out = W_CHANNEL'($urandom_range(0, 7));
            end
            tag32 = m_acc;
            case (mode)
                0: begin
                    acc_vld_i  = 1'b1;
                    pp_stall_i = 1'b0;
                    acc_data_i = {4{tag32 + 32'd1}};
                end
                2: begin
                    acc_vld_i  = 1'b1;
                    pp_stall_i = (it < 10);
                    acc_data_i = {~tag32, tag32, 32'h8000_0000, 32'h7FFF_FFFF};
                end
                default: begin
                    acc_vld_i  = ($urandom_range(0, 1) == 1);
                    pp_stall_i = ($urandom_range(0, 3) == 0);
                    acc_data_i = {$urandom, $urandom, $urandom, $urandom};
                end
            endcase
            if (mode == 2 && it == 10) begin
                check("stall_accepts", m_acc, 4);
                check("stall_rdy", acc_rdy_o, 0);
                check("stall_no_beats", beat, 0);
            end
            step();
            if (abort_after > 0 && beat == abort_after) break;
        end
        start_i = 1'b0; acc_vld_i = 1'b0; pp_stall_i = 1'b0;
        if (abort_after > 0) begin
            check("abort_point", beat, abort_after);
        end else begin
            check("done_seen", done_seen, 1);
            check("beat_count", beat, m_total);
            check("accept_count", m_acc, m_total);
            check("model_drained", exp_q.size(), 0);
            if (mode != 1 && m_total > 0) check("back_to_back", last_cyc - first_cyc, m_total - 1);
            if (mode == 0 && m_total > 0) check("first_latency", first_cyc - start_cyc, 3);
            step();
            check("done_pulse", done_o, 0);
            check("idle_after", busy_o, 0);
        end
        in_pass = 0;
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; acc_vld_i = 1'b0; pp_stall_i = 1'b0;
        acc_data_i = '0; q_width = '0; q_height = '0; q_channel = '0; q_channel_out = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        run_pass(2, 2, 1, 1, 0, 0);
        run_pass(1, 1, 3, 2, 0, 0);
        run_pass(2, 2, 1, 2, 2, 0);
        run_pass(3, 0, 2, 1, 0, 0);

        // Abort a pass with async reset after 3 of 8 beats, then rerun in full
        run_pass(2, 2, 2, 1, 0, 3);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        step();
        check("post_reset_idle", busy_o, 0);
        run_pass(2, 2, 2, 1, 0, 0);

        for (int p = 0; p < 6; p++) begin
            run_pass($urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(1, 2), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pe_psum_emitter

`default_nettype wire
